// File: rtl/jtmx5k_pkg.sv
// Shared definitions for the jtmx5k ROM slot.
// FSM state encoding and SDRAM word-address width.
package jtmx5k_pkg;

    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/jtmx5k_romslot_entry.sv
// One cache line of the ROM slot: valid bit, word tag and 16-bit data.
// Compares its tag against the current word address.
module jtmx5k_romslot_entry
    import jtmx5k_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_we,
    input  logic [SDRAM_AW-1:0] i_tag,
    input  logic [15:0]         i_data,
    input  logic [SDRAM_AW-1:0] i_addr,
    output logic                o_hit,
    output logic [15:0]         o_data
);

    logic                r_valid;
    logic [SDRAM_AW-1:0] r_tag;
    logic [15:0]         r_data;

    // Line storage: download invalidates, fill loads tag and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_we) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
            r_data  <= i_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_addr);
    assign o_data = r_data;

endmodule

// File: rtl/jtmx5k_romslot.sv
// ROM slot: caches SDRAM words for a client and fetches on a miss.
// JTMX5K_ROMSLOT_CACHE2_EN selects two lines with 1-bit LRU.
module jtmx5k_romslot
    import jtmx5k_pkg::*;
#(
    parameter int                  AW     = 18,
    parameter int                  DW     = 8,
    parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                slot_cs,
    input  logic [AW-1:0]       slot_addr,
    output logic                slot_ok,
    output logic [DW-1:0]       slot_dout,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);

`ifdef JTMX5K_ROMSLOT_CACHE2_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    state_t              r_state;
    state_t              w_next;
    logic                r_req;
    logic [SDRAM_AW-1:0] r_addr;
    logic [SDRAM_AW-1:0] w_waddr;
    logic [NE-1:0]       w_hit;
    logic [NE-1:0]       w_we;
    logic [15:0]         w_data [NE];
    logic [15:0]         w_word;
    logic                w_hit_any;
    logic                w_start;
    logic                w_fill;

    // Client address to SDRAM word address.
    always_comb begin
        if (DW == 8)
            w_waddr = OFFSET + SDRAM_AW'(slot_addr >> 1);
        else
            w_waddr = OFFSET + SDRAM_AW'(slot_addr);
    end

    for (genvar i = 0; i < NE; i++) begin : g_ent
        jtmx5k_romslot_entry u_ent (
            .clk    (clk),
            .rst    (rst),
            .i_clr  (downloading),
            .i_we   (w_we[i]),
            .i_tag  (r_addr),
            .i_data (data_read),
            .i_addr (w_waddr),
            .o_hit  (w_hit[i]),
            .o_data (w_data[i])
        );
    end

    assign w_hit_any = |w_hit;
    assign slot_ok   = slot_cs & ~downloading & w_hit_any;

    // Select the hitting line's word, entry 0 first.
    always_comb begin
        w_word = '0;
        for (int i = NE - 1; i >= 0; i--)
            if (w_hit[i]) w_word = w_data[i];
    end

    if (DW == 8) begin : g_b8
        assign slot_dout = slot_addr[0] ? w_word[15:8] : w_word[7:0];
    end else begin : g_b16
        assign slot_dout = w_word[DW-1:0];
    end

    // Fetch sequencing; download aborts and suppresses any fill.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_fill  = 1'b0;
        case (r_state)
            ST_IDLE:
                if (slot_cs && !w_hit_any && !downloading) begin
                    w_next  = ST_REQ;
                    w_start = 1'b1;
                end
            ST_REQ:
                if (sdram_ack) w_next = ST_WAIT;
            ST_WAIT:
                if (data_dst && data_rdy) begin
                    w_next = ST_IDLE;
                    w_fill = 1'b1;
                end
            default:
                w_next = ST_IDLE;
        endcase
        if (downloading) begin
            w_next  = ST_IDLE;
            w_start = 1'b0;
            w_fill  = 1'b0;
        end
    end

    // State, request strobe and the address held for the whole fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == ST_REQ);
            if (w_start) r_addr <= w_waddr;
        end
    end

    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;

`ifdef JTMX5K_ROMSLOT_CACHE2_EN
    logic r_lru;

    // LRU pointer: a fill or a hit makes that line most recent.
    always_ff @(posedge clk) begin
        if (rst)
            r_lru <= 1'b0;
        else if (w_fill)
            r_lru <= ~r_lru;
        else if (slot_ok)
            r_lru <= w_hit[0];
    end

    assign w_we = {w_fill & r_lru, w_fill & ~r_lru};
`else
    assign w_we = w_fill;
`endif

endmodule

// File: tb/tb_jtmx5k_romslot.sv
// Self-checking bench for jtmx5k_romslot (DW=8, OFFSET=22'h10000).
// Directed scenarios followed by random traffic against a queue model.
module tb_jtmx5k_romslot;

    localparam int          AW  = 18;
    localparam int          DW  = 8;
    localparam logic [21:0] OFS = 22'h10000;
`ifdef JTMX5K_ROMSLOT_CACHE2_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          downloading = 1'b0;
    logic          slot_cs = 1'b0;
    logic [AW-1:0] slot_addr = '0;
    logic          slot_ok;
    logic [DW-1:0] slot_dout;
    logic          sdram_req;
    logic [21:0]   sdram_addr;
    logic          sdram_ack = 1'b0;
    logic          data_dst = 1'b0;
    logic          data_rdy = 1'b0;
    logic [15:0]   data_read = '0;

    int n_chk = 0;
    int n_err = 0;
    int n_rise = 0;
    bit prev_req = 1'b0;

    typedef struct {
        logic [21:0] tag;
        logic [15:0] dat;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy = 1'b0;
    bit          m_acked = 1'b0;
    logic [21:0] m_faddr = '0;

    always #5 clk = ~clk;

    jtmx5k_romslot #(
        .AW     (AW),
        .DW     (DW),
        .OFFSET (OFS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_dst    (data_dst),
        .data_rdy    (data_rdy),
        .data_read   (data_read)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] waddr(input logic [AW-1:0] a);
        return OFS + 22'(a / 2);
    endfunction

    function automatic int lookup(input logic [21:0] w);
        for (int i = 0; i < m_q.size(); i++)
            if (m_q[i].tag == w) return i;
        return -1;
    endfunction

    task automatic drive(input bit r, input bit cs,
                         input logic [AW-1:0] a, input bit dl,
                         input bit ack, input bit dst, input bit rdy,
                         input logic [15:0] d);
        int          h;
        bit          hit;
        logic [15:0] word;
        @(negedge clk);
        rst = r;
        slot_cs = cs;
        slot_addr = a;
        downloading = dl;
        sdram_ack = ack;
        data_dst = dst;
        data_rdy = rdy;
        data_read = d;
        #1;
        h = lookup(waddr(a));
        hit = cs && !dl && (h >= 0);
        check("slot_ok", slot_ok, hit);
        if (hit) begin
            word = m_q[h].dat;
            check("slot_dout", slot_dout, a[0] ? word[15:8] : word[7:0]);
        end
        check("sdram_req", sdram_req, m_busy && !m_acked);
        if (m_busy) check("sdram_addr", sdram_addr, m_faddr);
        if (sdram_req && !prev_req) n_rise++;
        prev_req = sdram_req;
    endtask

    task automatic tick();
        int          h;
        ent_t        e;
        logic [21:0] w;
        @(posedge clk);
        w = waddr(slot_addr);
        h = lookup(w);
        if (rst) begin
            m_q.delete();
            m_busy = 1'b0;
            m_acked = 1'b0;
        end else if (downloading) begin
            m_q.delete();
            m_busy = 1'b0;
            m_acked = 1'b0;
        end else if (m_busy && m_acked && data_dst && data_rdy) begin
            if (m_q.size() == NE) void'(m_q.pop_back());
            e.tag = m_faddr;
            e.dat = data_read;
            m_q.push_front(e);
            m_busy = 1'b0;
        end else begin
            if (slot_cs && h >= 0) begin
                e = m_q[h];
                m_q.delete(h);
                m_q.push_front(e);
            end
            if (!m_busy) begin
                if (slot_cs && h < 0) begin
                    m_busy = 1'b1;
                    m_acked = 1'b0;
                    m_faddr = w;
                end
            end else if (!m_acked && sdram_ack) begin
                m_acked = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit cs,
                        input logic [AW-1:0] a, input bit dl,
                        input bit ack, input bit dst, input bit rdy,
                        input logic [15:0] d);
        drive(r, cs, a, dl, ack, dst, rdy, d);
        tick();
    endtask

    initial begin
        int rise0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ok", slot_ok, 0);
        check("rst_dout", slot_dout, 0);
        check("rst_req", sdram_req, 0);
        check("rst_addr", sdram_addr, 0);

        // cold miss
        step(0, 1, 18'h5, 0, 0, 0, 0, 16'h0);
        #1;
        check("cold_req", sdram_req, 1);
        check("cold_addr", sdram_addr, 22'h10002);
        step(0, 1, 18'h5, 0, 0, 1, 1, 16'h1111);
        step(0, 1, 18'h5, 0, 1, 0, 0, 16'h0);
        #1;
        check("cold_ack_req", sdram_req, 0);
        step(0, 1, 18'h5, 0, 0, 1, 1, 16'hBEEF);
        #1;
        check("cold_ok", slot_ok, 1);
        check("cold_dout", slot_dout, 8'hBE);

        // hit on the other byte
        drive(0, 1, 18'h4, 0, 0, 0, 0, 16'h0);
        check("hit_ok", slot_ok, 1);
        check("hit_dout", slot_dout, 8'hEF);
        tick();
        #1;
        check("hit_req", sdram_req, 0);

        // address change while waiting for data
        step(0, 1, 18'h100, 0, 0, 0, 0, 16'h0);
        #1;
        check("chg_addr1", sdram_addr, 22'h10080);
        step(0, 1, 18'h100, 0, 1, 0, 0, 16'h0);
        step(0, 1, 18'h200, 0, 0, 0, 0, 16'h0);
        step(0, 1, 18'h200, 0, 0, 1, 1, 16'h1234);
        drive(0, 1, 18'h100, 0, 0, 0, 0, 16'h0);
        check("chg_fill_ok", slot_ok, 1);
        check("chg_fill_dout", slot_dout, 8'h34);
        tick();
        step(0, 1, 18'h200, 0, 0, 0, 0, 16'h0);
        #1;
        check("chg_req2", sdram_req, 1);
        check("chg_addr2", sdram_addr, 22'h10100);
        step(0, 1, 18'h200, 0, 1, 0, 0, 16'h0);
        step(0, 1, 18'h200, 0, 0, 1, 1, 16'h5678);

        // download while a request is outstanding
        step(0, 1, 18'h8, 0, 0, 0, 0, 16'h0);
        drive(0, 1, 18'h200, 1, 0, 0, 0, 16'h0);
        check("dl_ok", slot_ok, 0);
        tick();
        #1;
        check("dl_req", sdram_req, 0);
        step(0, 1, 18'h8, 1, 1, 1, 1, 16'hAAAA);
        #1;
        check("dl_hold", sdram_req, 0);
        drive(0, 1, 18'h200, 0, 0, 0, 0, 16'h0);
        check("dl_remiss", slot_ok, 0);
        tick();
        #1;
        check("dl_refetch", sdram_req, 1);
        step(0, 1, 18'h200, 0, 1, 0, 0, 16'h0);
        step(0, 1, 18'h200, 0, 0, 1, 1, 16'h9ABC);

        // reset while waiting for data
        step(0, 1, 18'h20, 0, 0, 0, 0, 16'h0);
        step(0, 1, 18'h20, 0, 1, 0, 0, 16'h0);
        step(1, 1, 18'h20, 0, 0, 0, 0, 16'h0);
        step(0, 0, 18'h20, 0, 0, 1, 1, 16'hDEAD);
        drive(0, 1, 18'h20, 0, 0, 0, 0, 16'h0);
        check("rstw_ok", slot_ok, 0);
        check("rstw_req", sdram_req, 0);
        tick();
        step(0, 1, 18'h20, 0, 1, 0, 0, 16'h0);
        step(0, 1, 18'h20, 0, 0, 1, 1, 16'h4321);

        // alternate two addresses, then a third one
        step(1, 0, 18'h0, 0, 0, 0, 0, 16'h0);
        rise0 = n_rise;
        for (int i = 0; i < 12; i++)
            step(0, 1, (i % 2) ? 18'h2 : 18'h0, 0, 1, 1, 1,
                 16'h0F00 + 16'(i));
`ifdef JTMX5K_ROMSLOT_CACHE2_EN
        check("two_reqs", n_rise - rise0, 2);
`endif
        step(0, 1, 18'h4, 0, 0, 0, 0, 16'h0);
        step(0, 1, 18'h4, 0, 1, 0, 0, 16'h0);
        step(0, 1, 18'h4, 0, 0, 1, 1, 16'h7777);
        drive(0, 1, 18'h2, 0, 0, 0, 0, 16'h0);
        check("evict_mru", slot_ok, (NE == 2) ? 1 : 0);
        tick();
        drive(0, 1, 18'h0, 0, 0, 0, 0, 16'h0);
        check("evict_lru", slot_ok, 0);
        tick();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [AW-1:0] a;
            a = ($urandom % 8 == 0) ? AW'($urandom)
                                    : AW'($urandom_range(0, 9));
            step(($urandom % 300) == 0,
                 ($urandom % 4) != 0,
                 a,
                 ($urandom % 60) == 0,
                 ($urandom % 3) == 0,
                 ($urandom % 2) == 0,
                 ($urandom % 2) == 0,
                 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/jtmx5k_romslot.md
JTMX5K_ROMSLOT -- requirements
Module: jtmx5k_romslot

Interface
REQ-001 SHALL have parameter AW, default 18, client address width.
REQ-002 SHALL have parameter DW, default 8, client data width (8 or 16).
REQ-003 SHALL have parameter OFFSET, default 22'h0, SDRAM word offset added to every request.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port downloading  in  1  ROM download in progress.
REQ-007 SHALL have ports slot_cs in 1, slot_addr in AW, slot_ok out 1, slot_dout out DW: client request, address, data-valid and data.
REQ-008 SHALL have ports sdram_req out 1, sdram_addr out 22, sdram_ack in 1, data_dst in 1, data_rdy in 1, data_read in 16: SDRAM word-read handshake.

Function
REQ-009 SHALL compute the word address as OFFSET + slot_addr>>1 when DW=8, and as OFFSET + slot_addr when DW=16, truncated to 22 bits.
REQ-010 SHALL hold a cache entry {valid, tag=word address, data[15:0]}.
REQ-011 SHALL drive slot_ok combinationally as slot_cs & ~downloading & hit, where hit means an entry is valid and its tag equals the current word address.
REQ-012 SHALL drive slot_dout from the hit entry: for DW=8, data[7:0] when slot_addr[0]=0 and data[15:8] when slot_addr[0]=1; for DW=16, data[15:0].
REQ-013 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-014 SHALL leave IDLE for REQ on slot_cs & ~hit & ~downloading, registering sdram_addr at that edge.
REQ-015 SHALL hold sdram_req=1 in REQ until sdram_ack=1, then go to WAIT with sdram_req=0 on the following cycle.
REQ-016 SHALL capture data_read in WAIT on the cycle data_dst & data_rdy, writing tag=sdram_addr and valid=1, then return to IDLE.
REQ-017 SHALL ignore data_dst/data_rdy outside WAIT.
REQ-018 SHALL complete an in-flight fetch even if slot_cs drops or slot_addr changes; the hit test then re-evaluates in IDLE and a new miss starts a new REQ.
REQ-019 SHALL give miss-to-ok latency = 1 (IDLE->REQ) + ack wait + data wait + 1 cycle.
REQ-020 SHALL force, on downloading=1, state IDLE, sdram_req=0 and all entries invalid, with no fetch until downloading=0.
REQ-021 SHALL keep sdram_addr stable from the REQ entry until the WAIT capture.

Reset
REQ-022 SHALL on rst set state=IDLE, sdram_req=0, sdram_addr=0, all valid=0 and all data/tags=0, so slot_ok=0 and slot_dout=0.
REQ-023 SHALL let rst mid-fetch abandon the transaction; a late data_rdy after rst SHALL NOT write the cache.

Configuration
REQ-024 SHALL, with JTMX5K_ROMSLOT_CACHE2_EN defined, hold two entries with a 1-bit LRU: a fill replaces the LRU entry, and a hit or fill marks that entry MRU; reset sets LRU=entry 0.
REQ-025 SHALL, without JTMX5K_ROMSLOT_CACHE2_EN, hold a single entry that each fill overwrites.

Structure
REQ-026 SHALL place the FSM state encoding (IDLE, REQ, WAIT) and the SDRAM address width constant (22) in the shared package jtmx5k_pkg.
REQ-027 SHALL implement each cache entry as the sub-module jtmx5k_romslot_entry (tag compare plus data register), instantiated once, or twice with JTMX5K_ROMSLOT_CACHE2_EN.

Verification
REQ-028 SHALL cover a cold miss: DW=8, OFFSET=22'h10000, slot_addr=18'h00005, cs=1 -> sdram_req=1 with sdram_addr=22'h10002; after ack and rdy with data_read=16'hBEEF, slot_ok=1 and slot_dout=8'hBE.
REQ-029 SHALL cover a hit: then slot_addr=18'h00004 -> slot_ok=1 in the same cycle, slot_dout=8'hEF, sdram_req stays 0.
REQ-030 SHALL cover an address change mid-fetch: slot_addr changes 18'h00100 -> 18'h00200 while in WAIT -> the first fill completes (tag 22'h10080), then a second request with sdram_addr=22'h10100.
REQ-031 SHALL cover download: downloading=1 while in REQ -> sdram_req=0 next cycle, slot_ok=0; after downloading=0 a previously cached address misses again.
REQ-032 SHALL cover reset mid-fetch: rst in WAIT, then data_rdy=1 -> no cache write, slot_ok=0, state IDLE.
REQ-033 SHALL cover two entries (CACHE2_EN): alternate slot_addr 18'h0 and 18'h2 -> exactly two SDRAM requests in total; a third address 18'h4 evicts the LRU entry.
